// File: rtl/cu_fsm_pkg.sv
// Shared RV32I control definitions: opcode encodings, SYSTEM func3 codes
// and the PC-source select used by the decoder.
package cu_fsm_pkg;

  typedef enum logic [6:0] {
    OP_LOAD   = 7'b0000011,
    OP_IMM    = 7'b0010011,
    OP_AUIPC  = 7'b0010111,
    OP_STORE  = 7'b0100011,
    OP_RG3    = 7'b0110011,
    OP_LUI    = 7'b0110111,
    OP_BRANCH = 7'b1100011,
    OP_JALR   = 7'b1100111,
    OP_JAL    = 7'b1101111,
    OP_SYS    = 7'b1110011
  } opcode_t;

  localparam logic [2:0] F3_MRET  = 3'b000;
  localparam logic [2:0] F3_CSRRW = 3'b001;

  // PC mux select driven by the decoder; PC_MTVEC is forced on int_taken.
  typedef enum logic [2:0] {
    PC_PLUS4  = 3'b000,
    PC_JALR   = 3'b001,
    PC_BRANCH = 3'b010,
    PC_JAL    = 3'b011,
    PC_MTVEC  = 3'b100,
    PC_MEPC   = 3'b101
  } pc_source_t;

  // Opcodes whose single EXEC cycle writes rd (LOAD writes rd in WB instead).
  function automatic logic writes_rd_in_exec(input opcode_t op);
    case (op)
      OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_IMM, OP_RG3: writes_rd_in_exec = 1'b1;
      default:                                           writes_rd_in_exec = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/cu_fsm.sv
// Multicycle RV32I control unit: FETCH/EXEC(/WB) per instruction, with
// interrupt entry only on instruction boundaries.
module cu_fsm
  import cu_fsm_pkg::*;
(
  input  logic       CLK,
  input  logic       RST,
  input  logic       intr,
  input  logic       mie,
  input  logic [6:0] opcode,
  input  logic [2:0] func3,
  output logic       pcWrite,
  output logic       regWrite,
  output logic       memWE2,
  output logic       memRDEN1,
  output logic       memRDEN2,
  output logic       int_taken,
  output logic       csr_WE,
  output logic       mret_exec,
  output logic       reset,
  output logic [2:0] state_dbg
);

  typedef enum logic [2:0] {
    ST_INIT  = 3'd0,
    ST_FETCH = 3'd1,
    ST_EXEC  = 3'd2,
    ST_WB    = 3'd3,
    ST_INTR  = 3'd4
  } state_t;

  state_t  state, state_nxt;
  opcode_t op;
  logic    irq;

  assign op        = opcode_t'(opcode);
  assign irq       = intr & mie;
  assign state_dbg = state;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= ST_INIT;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = ST_INIT;
    pcWrite   = 1'b0;
    regWrite  = 1'b0;
    memWE2    = 1'b0;
    memRDEN1  = 1'b0;
    memRDEN2  = 1'b0;
    int_taken = 1'b0;
    csr_WE    = 1'b0;
    mret_exec = 1'b0;
    reset     = 1'b0;

    case (state)
      ST_INIT: begin
        reset     = 1'b1;
        state_nxt = ST_FETCH;
      end

      ST_FETCH: begin
        memRDEN1  = 1'b1;
        state_nxt = ST_EXEC;
      end

      ST_EXEC: begin
        // Every non-LOAD instruction retires here, so it is an interrupt boundary.
        state_nxt = irq ? ST_INTR : ST_FETCH;
        pcWrite   = 1'b1;
        if (op == OP_LOAD) begin
          memRDEN2  = 1'b1;
          pcWrite   = 1'b0;
          state_nxt = ST_WB;
        end else if (op == OP_STORE) begin
          memWE2 = 1'b1;
        end else if (writes_rd_in_exec(op)) begin
          regWrite = 1'b1;
        end else if (op == OP_SYS) begin
          if (func3 == F3_CSRRW) begin
            regWrite = 1'b1;
            csr_WE   = 1'b1;
          end else if (func3 == F3_MRET) begin
            mret_exec = 1'b1;
          end
        end
      end

      ST_WB: begin
        regWrite  = 1'b1;
        pcWrite   = 1'b1;
        state_nxt = irq ? ST_INTR : ST_FETCH;
      end

      ST_INTR: begin
        int_taken = 1'b1;
        pcWrite   = 1'b1;
        state_nxt = ST_FETCH;
      end

      default: state_nxt = ST_INIT;
    endcase
  end

endmodule

// File: tb/tb_cu_fsm.sv
// Directed bench for cu_fsm: the driver queues the expected state/outputs
// for each cycle, and a monitor pops and compares them independently.
module tb_cu_fsm;

  logic       CLK = 1'b0;
  logic       RST;
  logic       intr, mie;
  logic [6:0] opcode;
  logic [2:0] func3;
  logic       pcWrite, regWrite, memWE2, memRDEN1, memRDEN2;
  logic       int_taken, csr_WE, mret_exec, reset;
  logic [2:0] state_dbg;

  localparam logic [2:0] S_INIT = 3'd0, S_FETCH = 3'd1, S_EXEC = 3'd2,
                         S_WB = 3'd3, S_INTR = 3'd4;

  // Output order: pcWrite regWrite memWE2 memRDEN1 memRDEN2 int_taken csr_WE mret_exec reset
  localparam logic [8:0] O_INIT  = 9'b000000001;
  localparam logic [8:0] O_FETCH = 9'b000100000;
  localparam logic [8:0] O_LOAD  = 9'b000010000;
  localparam logic [8:0] O_STORE = 9'b101000000;
  localparam logic [8:0] O_WR    = 9'b110000000;
  localparam logic [8:0] O_PC    = 9'b100000000;
  localparam logic [8:0] O_CSR   = 9'b110000100;
  localparam logic [8:0] O_MRET  = 9'b100000010;
  localparam logic [8:0] O_INTR  = 9'b100001000;

  localparam logic [6:0] LOAD = 7'b0000011, STORE = 7'b0100011, RG3 = 7'b0110011,
                         SYS = 7'b1110011, BRANCH = 7'b1100011, JAL = 7'b1101111,
                         BOGUS = 7'b1111111;

  logic [11:0] exp_q[$];
  string       name_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;

  // Clock and reset
  initial forever #5 CLK = ~CLK;

  cu_fsm dut (
    .CLK(CLK), .RST(RST), .intr(intr), .mie(mie), .opcode(opcode), .func3(func3),
    .pcWrite(pcWrite), .regWrite(regWrite), .memWE2(memWE2), .memRDEN1(memRDEN1),
    .memRDEN2(memRDEN2), .int_taken(int_taken), .csr_WE(csr_WE),
    .mret_exec(mret_exec), .reset(reset), .state_dbg(state_dbg)
  );

  // Driver: applies inputs for the coming cycle and queues what it must show.
  task automatic cyc(input string nm, input logic [6:0] op, input logic [2:0] f3,
                     input logic ir, input logic me, input logic [2:0] st,
                     input logic [8:0] o);
    @(posedge CLK);
    #1;
    opcode = op; func3 = f3; intr = ir; mie = me;
    exp_q.push_back({st, o});
    name_q.push_back(nm);
  endtask

  // Monitor / scoreboard
  initial begin
    logic [11:0] act, e;
    string       nm;
    forever begin
      @(negedge CLK or posedge RST);
      #1;
      if (exp_q.size() > 0) begin
        act = {state_dbg, pcWrite, regWrite, memWE2, memRDEN1, memRDEN2,
               int_taken, csr_WE, mret_exec, reset};
        e   = exp_q.pop_front();
        nm  = name_q.pop_front();
        n_cmp++;
        if (act !== e) begin
          n_bad++;
          $display("FAIL %s: got state=%0d out=%b, expected state=%0d out=%b",
                   nm, act[11:9], act[8:0], e[11:9], e[8:0]);
        end
      end
    end
  end

  initial begin
    RST = 1'b1; intr = 1'b0; mie = 1'b0; opcode = '0; func3 = '0;
    #3;
    exp_q.push_back({S_INIT, O_INIT});
    name_q.push_back("reset_init");
    @(negedge CLK);
    #2 RST = 1'b0;

    cyc("load_fetch",  LOAD,  3'b010, 1'b0, 1'b0, S_FETCH, O_FETCH);
    cyc("load_exec",   LOAD,  3'b010, 1'b0, 1'b0, S_EXEC,  O_LOAD);
    cyc("load_wb",     LOAD,  3'b010, 1'b0, 1'b0, S_WB,    O_WR);

    cyc("store_fetch", STORE, 3'b010, 1'b0, 1'b0, S_FETCH, O_FETCH);
    cyc("store_exec",  STORE, 3'b010, 1'b0, 1'b0, S_EXEC,  O_STORE);

    // Interrupt pending during FETCH must wait for the boundary.
    cyc("rg3_irq_fetch", RG3, 3'b000, 1'b1, 1'b1, S_FETCH, O_FETCH);
    cyc("rg3_irq_exec",  RG3, 3'b000, 1'b1, 1'b1, S_EXEC,  O_WR);
    cyc("rg3_irq_intr",  RG3, 3'b000, 1'b1, 1'b1, S_INTR,  O_INTR);
    cyc("rg3_nomie_fetch", RG3, 3'b000, 1'b1, 1'b0, S_FETCH, O_FETCH);
    cyc("rg3_nomie_exec",  RG3, 3'b000, 1'b1, 1'b0, S_EXEC,  O_WR);

    cyc("csrrw_fetch", SYS, 3'b001, 1'b0, 1'b0, S_FETCH, O_FETCH);
    cyc("csrrw_exec",  SYS, 3'b001, 1'b0, 1'b0, S_EXEC,  O_CSR);

    cyc("mret_fetch", SYS, 3'b000, 1'b1, 1'b1, S_FETCH, O_FETCH);
    cyc("mret_exec",  SYS, 3'b000, 1'b1, 1'b1, S_EXEC,  O_MRET);
    cyc("mret_intr",  SYS, 3'b000, 1'b1, 1'b1, S_INTR,  O_INTR);

    // LOAD is not abandoned mid-way; the interrupt follows WB.
    cyc("load_irq_fetch", LOAD, 3'b010, 1'b1, 1'b1, S_FETCH, O_FETCH);
    cyc("load_irq_exec",  LOAD, 3'b010, 1'b1, 1'b1, S_EXEC,  O_LOAD);
    cyc("load_irq_wb",    LOAD, 3'b010, 1'b1, 1'b1, S_WB,    O_WR);
    cyc("load_irq_intr",  LOAD, 3'b010, 1'b0, 1'b1, S_INTR,  O_INTR);

    cyc("branch_fetch", BRANCH, 3'b000, 1'b0, 1'b0, S_FETCH, O_FETCH);
    cyc("branch_exec",  BRANCH, 3'b000, 1'b0, 1'b0, S_EXEC,  O_PC);
    cyc("bogus_fetch",  BOGUS,  3'b000, 1'b0, 1'b0, S_FETCH, O_FETCH);
    cyc("bogus_exec",   BOGUS,  3'b000, 1'b0, 1'b0, S_EXEC,  O_PC);
    cyc("sys010_fetch", SYS,    3'b010, 1'b0, 1'b0, S_FETCH, O_FETCH);
    cyc("sys010_exec",  SYS,    3'b010, 1'b0, 1'b0, S_EXEC,  O_PC);
    cyc("jal_fetch",    JAL,    3'b000, 1'b0, 1'b0, S_FETCH, O_FETCH);
    cyc("jal_exec",     JAL,    3'b000, 1'b0, 1'b0, S_EXEC,  O_WR);

    // Asynchronous reset in the middle of a STORE's EXEC cycle.
    cyc("store2_fetch", STORE, 3'b010, 1'b0, 1'b0, S_FETCH, O_FETCH);
    cyc("store2_exec",  STORE, 3'b010, 1'b0, 1'b0, S_EXEC,  O_STORE);
    @(negedge CLK);
    #3;
    exp_q.push_back({S_INIT, O_INIT});
    name_q.push_back("async_rst");
    RST = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    #2 RST = 1'b0;
    cyc("post_rst_fetch", RG3, 3'b000, 1'b0, 1'b0, S_FETCH, O_FETCH);
    cyc("post_rst_exec",  RG3, 3'b000, 1'b0, 1'b0, S_EXEC,  O_WR);

    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge CLK);
    #2;
    if (exp_q.size() > 0) begin
      n_bad++;
      $display("FAIL drain: got %0d entries left, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #50000;
    n_bad++;
    $display("FAIL watchdog: got timeout, expected bench completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cu_fsm.md
CU_FSM -- requirements
Module: cu_fsm

Interface
REQ-001 The block SHALL have no parameters.
REQ-002 CLK  input  1  sole clock; all state updates on rising edge.
REQ-003 RST  input  1  reset; asynchronous and active-high.
REQ-004 intr  input  1  external interrupt request, already synchronized to CLK, level-sensitive.
REQ-005 mie  input  1  machine interrupt enable from the CSR file.
REQ-006 opcode  input  7  ir[6:0] of the current instruction.
REQ-007 func3  input  3  ir[14:12] of the current instruction.
REQ-008 pcWrite  output  1  PC register load enable.
REQ-009 regWrite  output  1  register file write enable.
REQ-010 memWE2  output  1  data-port write enable.
REQ-011 memRDEN1  output  1  instruction-port read enable.
REQ-012 memRDEN2  output  1  data-port read enable.
REQ-013 int_taken  output  1  interrupt entry; feeds the decoder, which forces pcSource=3'b100 when it is high.
REQ-014 csr_WE  output  1  CSR write enable for csrrw.
REQ-015 mret_exec  output  1  mret executing; the CSR file restores mie.
REQ-016 reset  output  1  synchronous clear request to PC and CSR file.

Function
REQ-017 States SHALL be ST_INIT, ST_FETCH, ST_EXEC, ST_WB and ST_INTR, held in a single state register.
REQ-018 Outputs SHALL be combinational from the state (and from opcode/func3 in ST_EXEC); any output not named for a state SHALL be 0.
REQ-019 ST_INIT: reset=1; next state ST_FETCH unconditionally.
REQ-020 ST_FETCH: memRDEN1=1; next state ST_EXEC unconditionally.
REQ-021 ST_EXEC, LOAD (0000011): memRDEN2=1; pcWrite=0; next state ST_WB.
REQ-022 ST_EXEC, STORE (0100011): memWE2=1, pcWrite=1.
REQ-023 ST_EXEC, BRANCH (1100011): pcWrite=1 only.
REQ-024 ST_EXEC, LUI, AUIPC, JAL, JALR, OP_IMM, OP_RG3: regWrite=1, pcWrite=1.
REQ-025 ST_EXEC, SYS (1110011), func3=001 (csrrw): regWrite=1, csr_WE=1, pcWrite=1.
REQ-026 ST_EXEC, SYS (1110011), func3=000 (mret): mret_exec=1, pcWrite=1.
REQ-027 ST_EXEC, other SYS func3 and every unlisted opcode: pcWrite=1 only (treated as a NOP; no trap).
REQ-028 ST_WB: regWrite=1, pcWrite=1.
REQ-029 Exit from ST_EXEC (non-LOAD) and from ST_WB SHALL go to ST_INTR if (intr & mie) is 1 in that cycle, else to ST_FETCH.
REQ-030 ST_INTR: int_taken=1, pcWrite=1; next state ST_FETCH unconditionally; intr is ignored in this state.
REQ-031 Latency SHALL be 2 cycles per instruction, 3 for LOAD, plus 1 when an interrupt is taken.
REQ-032 An interrupt SHALL be taken only at an instruction boundary; an instruction is never abandoned in ST_FETCH or mid-LOAD.
REQ-033 Simultaneous mret_exec and (intr & mie) in ST_EXEC: the mret completes and the next state is ST_INTR.
REQ-034 Unreachable state encodings SHALL go to ST_INIT.

Reset
REQ-035 RST=1 SHALL force ST_INIT immediately, from any state, without waiting for CLK.
REQ-036 While in ST_INIT, reset=1 and all other outputs SHALL be 0.
REQ-037 After RST deasserts, the first rising edge SHALL move the state to ST_FETCH.

Structure
REQ-038 opcode_t (the RV32I opcode enum) and the func3 codes for csrrw/mret SHALL live in the shared package, together with the decoder's enum.
REQ-039 The state enum SHALL be local to cu_fsm.
REQ-040 No sub-module is natural: cu_fsm is one state register plus one next-state/output combinational process.

Verification
REQ-041 RST pulse then release -> ST_INIT (reset=1), then ST_FETCH (memRDEN1=1), then ST_EXEC.
REQ-042 opcode=0000011 -> FETCH memRDEN1=1; EXEC memRDEN2=1, pcWrite=0; WB regWrite=1, pcWrite=1; back to FETCH after 3 cycles.
REQ-043 opcode=0100011 -> EXEC memWE2=1, pcWrite=1, regWrite=0; next state FETCH.
REQ-044 opcode=0110011 with intr=1, mie=1 in EXEC -> EXEC regWrite=1; INTR int_taken=1, pcWrite=1; then FETCH. Repeat with mie=0 -> no INTR.
REQ-045 opcode=1110011 -> func3=001 gives csr_WE=1 and regWrite=1; func3=000 gives mret_exec=1 and regWrite=0.
REQ-046 RST asserted mid-EXEC of opcode=0100011 -> memWE2 drops to 0 at once and reset=1 before the next CLK edge.
